fpdiv_seq: RTL
==============

Name: fpdiv_seq

Overview:
Sequential floating-point divider for the team's 13-bit format: sign [12], exponent [11:8] with bias 7, mantissa U(8.7) [7:0] with an explicit leading one.
It is the inverse operation to the combinational floating-point multiplier and shares its special encodings.
- +/-zero: exp 4'h7, mant 0.
- +/-inf: exp 4'hF, mant 0.
- NaN: 13'h1F80.

It computes o_quot = i_dividend / i_divisor using an iterative restoring mantissa division with a valid/ready handshake. It sits in the FP datapath beside the multiplier.

Parameters:
NB_EXP, 4, exponent width
NB_MANT, 8, mantissa width (U(NB_MANT.NB_MANT-1)); data width = 1+NB_EXP+NB_MANT
BIAS, 7, exponent bias
NB_ITER, 10, quotient bits produced (NB_MANT+2: 1 normalisation bit + 1 round bit)
Only the defaults are verified.

Ports:
i_clock     in   1   clock, rising edge
i_reset     in   1   asynchronous, active-high reset
i_valid     in   1   request; operands sampled when i_valid & o_ready
i_dividend  in   13  dividend
i_divisor   in   13  divisor
o_ready     out  1   high only in IDLE
o_valid     out  1   one-cycle result strobe
o_quot      out  13  quotient; held until the next result

Behaviour:
- Reset values (asynchronous): state IDLE, o_ready=1, o_valid=0, o_quot=13'h0700 (+0), counter 0, datapath regs 0.
- Reset asserted mid-operation aborts it: no o_valid is produced and the block returns to IDLE.

FSM states: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE: on edge with i_valid=1, capture operands, compute sign = s1^s2, classify operands, load remainder=M1, divisor=M2, cnt=0, go to DIV. i_valid=0 stays in IDLE.
- DIV: exactly NB_ITER cycles, one restoring step per cycle.
  - Each step: trial = rem - M2. If trial >= 0, rem = trial<<1 and q bit = 1; else rem = rem<<1 and q bit = 0.
  - Result is Qr = floor(M1*2^9/M2), a 10-bit value.
- NORM: 1 cycle; computes the result and registers it into o_quot.
- DONE: o_valid=1, o_ready=0 for 1 cycle, then back to IDLE.

Timing:
- o_valid is high in the cycle following the 11th edge after the accept edge. Latency is fixed for all operand classes, including special cases.
- Earliest next accept is the first edge after DONE (throughput = 1 result per 13 cycles).
- i_valid while not in IDLE is ignored; it is not queued.

Arithmetic (signed exponent, 6 bits wide):
- Base exponent: E = E1 - E2 + BIAS.
- If Qr[9]=1: mant = Qr[9:2] + Qr[1]. Otherwise: mant = Qr[8:1] + Qr[0] and E = E - 1.
- Round-half-up cannot overflow for normalised operands. Mantissa saturates at 8'hFF as a safeguard.
- E > 14 -> {sign, inf}. E < 0 -> {sign, zero} (flush to zero). Otherwise {sign, E[3:0], mant}.

Special cases (exact 12-bit magnitude match, priority order):
1. Either operand NaN, 0/0, or inf/inf -> 13'h1F80.
2. inf/finite or finite/0 -> {sign, inf}.
3. 0/x or finite/inf -> {sign, zero}.

Other operands: non-normalised operands (mant[7]=0, not special) give an unspecified o_quot but keep the same latency. The block never hangs.

Decomposition:
- Shared header fp_defs.vh holds BIAS, NB_EXP, NB_MANT, and the NAN/INF/ZERO encodings. It is used by both the multiplier and this block.
- One sub-module, fpdiv_mant_core: holds the restoring-division remainder/quotient registers and the iteration counter. Inputs: start, M1, M2. Outputs: Qr and done.
- fpdiv_seq holds the FSM, operand classification, normalisation, rounding and exponent checks.

Test Plan:
- 0x0780 / 0x0780 (1.0/1.0) -> o_quot=0x0780. o_valid high exactly 11 cycles after the accept edge, for one cycle; o_ready low throughout.
- 0x18C0 / 0x0880 (-3.0/2.0) -> 0x17C0 (-1.5). Then 0x0780 / 0x07C0 (1.0/1.5) -> 0x06AB (normalisation shift, rounding up).
- Specials:
  - 0x0780 / 0x0700 -> 0x0F00.
  - 0x0700 / 0x0700 -> 0x1F80.
  - 0x1780 / 0x0F00 -> 0x1700.
  - 0x1F80 / 0x0780 -> 0x1F80.
  - All with the same 11-cycle latency.
- Range: 0x0E80 / 0x0080 -> 0x0F00 (overflow). 0x0080 / 0x0E80 -> 0x0700 (underflow flush).
- Handshake: i_valid held high continuously -> operands accepted only in IDLE, one result per 13 cycles. New operands changed during DIV do not affect the in-flight result.
- Assert i_reset during cycle 5 of DIV -> o_valid stays 0, o_quot=0x0700, o_ready=1 immediately. Next request completes normally.

Source files
------------

// File: rtl/fpdiv_seq_pkg.sv
// Shared definitions for the sequential floating-point divider.
// Default field widths and bias of the 13-bit FP format (sign, 4-bit biased exponent,
// U(8.7) mantissa with explicit leading one) and the control FSM state type.
package fpdiv_seq_pkg;

    localparam int unsigned FP_NB_EXP  = 4;
    localparam int unsigned FP_NB_MANT = 8;
    localparam int unsigned FP_BIAS    = 7;
    // One normalisation bit plus one round bit beyond the mantissa.
    localparam int unsigned FP_NB_ITER = FP_NB_MANT + 2;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StNorm,
        StDone
    } state_t;

endpackage

// File: rtl/fpdiv_mant_core.sv
// Restoring mantissa divider core.
// A start pulse loads remainder = m1 and divisor = m2. Each following cycle performs one
// restoring step and shifts one quotient bit into qr (MSB first). After NB_ITER steps
// qr = floor(m1 * 2^(NB_ITER-1) / m2) for normalised operands.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : load operands and begin a division
//   m1_i    : dividend mantissa
//   m2_i    : divisor mantissa
//   qr_o    : quotient register
//   done_o  : high in the cycle whose closing edge performs the final step
module fpdiv_mant_core
    import fpdiv_seq_pkg::*;
#(
    parameter int unsigned NB_MANT = FP_NB_MANT,
    parameter int unsigned NB_ITER = FP_NB_ITER
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NB_MANT-1:0] m1_i,
    input  logic [NB_MANT-1:0] m2_i,
    output logic [NB_ITER-1:0] qr_o,
    output logic               done_o
);

    localparam int unsigned NB_REM = NB_MANT + 2;
    localparam int unsigned NB_CNT = $clog2(NB_ITER);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_ITER - 1);

    logic [NB_REM-1:0]  rem_q, rem_d;
    logic [NB_MANT-1:0] dvs_q;
    logic [NB_ITER-1:0] qr_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               busy_q;

    logic [NB_REM:0]    trial;
    logic               trial_ge;
    logic [NB_REM-1:0]  rem_keep;

    // One extra bit so the sign of the trial subtraction is visible.
    always_comb begin
        trial    = {1'b0, rem_q} - {{(NB_REM - NB_MANT + 1){1'b0}}, dvs_q};
        trial_ge = ~trial[NB_REM];
        rem_keep = trial_ge ? trial[NB_REM-1:0] : rem_q;
        rem_d    = {rem_keep[NB_REM-2:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            qr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= {2'b00, m1_i};
            dvs_q  <= m2_i;
            qr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            qr_q  <= {qr_q[NB_ITER-2:0], trial_ge};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign qr_o   = qr_q;
    assign done_o = busy_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fpdiv_seq.sv
// Sequential floating-point divider, o_quot = i_dividend / i_divisor.
// Operands are accepted in IDLE, the mantissa quotient is produced by a restoring core over
// NB_ITER cycles, then normalised, rounded (half-up) and range checked in one cycle.
// Latency from the accept edge to o_valid is fixed for every operand class.
// Ports:
//   i_clock    : clock, rising edge
//   i_reset    : asynchronous active-high reset
//   i_valid    : request; operands sampled when i_valid & o_ready
//   i_dividend : dividend
//   i_divisor  : divisor
//   o_ready    : high only in IDLE
//   o_valid    : one-cycle result strobe
//   o_quot     : quotient, held until the next result
module fpdiv_seq
    import fpdiv_seq_pkg::*;
#(
    parameter int unsigned NB_EXP  = FP_NB_EXP,
    parameter int unsigned NB_MANT = FP_NB_MANT,
    parameter int unsigned BIAS    = FP_BIAS,
    parameter int unsigned NB_ITER = FP_NB_ITER
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [NB_EXP+NB_MANT:0]       i_dividend,
    input  logic [NB_EXP+NB_MANT:0]       i_divisor,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic [NB_EXP+NB_MANT:0]       o_quot
);

    localparam int unsigned NB_DATA = 1 + NB_EXP + NB_MANT;
    localparam int unsigned NB_MAG  = NB_DATA - 1;
    // Exponent arithmetic is done two bits wider and signed to catch over/underflow.
    localparam int unsigned NB_E    = NB_EXP + 2;

    localparam logic [NB_EXP-1:0] EXP_ONES = '1;
    localparam logic [NB_EXP-1:0] EXP_BIAS = NB_EXP'(BIAS);
    localparam logic [NB_MAG-1:0] MAG_INF  = {EXP_ONES, {NB_MANT{1'b0}}};
    localparam logic [NB_MAG-1:0] MAG_ZERO = {EXP_BIAS, {NB_MANT{1'b0}}};
    localparam logic [NB_MAG-1:0] MAG_NAN  = {EXP_ONES, 1'b1, {(NB_MANT - 1){1'b0}}};

    localparam logic signed [NB_E-1:0] E_BIAS = NB_E'(BIAS);
    localparam logic signed [NB_E-1:0] E_ONE  = NB_E'(1);
    localparam logic signed [NB_E-1:0] E_MAX  = NB_E'((1 << NB_EXP) - 2);

    state_t state_q, state_d;

    logic start;
    logic norm_en;
    logic core_done;
    logic [NB_ITER-1:0] qr;

    // Captured operand information.
    logic                   sign_q;
    logic signed [NB_E-1:0] exp_q;
    logic                   spec_hit_q;
    logic [NB_DATA-1:0]     spec_val_q;
    logic [NB_DATA-1:0]     quot_q;

    // Operand classification.
    logic [NB_MAG-1:0]      mag_a, mag_b;
    logic                   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic                   sign_in;
    logic                   spec_hit_d;
    logic [NB_DATA-1:0]     spec_val_d;
    logic signed [NB_E-1:0] exp_a_ext, exp_b_ext, exp_in;

    // Normalisation and rounding.
    logic [NB_MANT:0]       mant_sum;
    logic [NB_MANT-1:0]     mant_rnd;
    logic signed [NB_E-1:0] exp_norm;
    logic [NB_DATA-1:0]     quot_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_valid) state_d = StDiv;
            StDiv:   if (core_done) state_d = StNorm;
            StNorm:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_ready = (state_q == StIdle);
        o_valid = (state_q == StDone);
        start   = (state_q == StIdle) && i_valid;
        norm_en = (state_q == StNorm);
    end

    // ---------------------------------------------------------------- classification
    always_comb begin
        mag_a  = i_dividend[NB_MAG-1:0];
        mag_b  = i_divisor[NB_MAG-1:0];
        a_nan  = (mag_a == MAG_NAN);
        a_inf  = (mag_a == MAG_INF);
        a_zero = (mag_a == MAG_ZERO);
        b_nan  = (mag_b == MAG_NAN);
        b_inf  = (mag_b == MAG_INF);
        b_zero = (mag_b == MAG_ZERO);

        sign_in    = i_dividend[NB_DATA-1] ^ i_divisor[NB_DATA-1];
        spec_hit_d = 1'b1;
        spec_val_d = {1'b1, MAG_NAN};
        // Priority order matters: 0/0 and inf/inf are NaN before the inf/zero rules apply.
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_val_d = {1'b1, MAG_NAN};
        end else if (a_inf || b_zero) begin
            spec_val_d = {sign_in, MAG_INF};
        end else if (a_zero || b_inf) begin
            spec_val_d = {sign_in, MAG_ZERO};
        end else begin
            spec_hit_d = 1'b0;
        end

        exp_a_ext = signed'({2'b00, i_dividend[NB_MANT +: NB_EXP]});
        exp_b_ext = signed'({2'b00, i_divisor[NB_MANT +: NB_EXP]});
        exp_in    = exp_a_ext - exp_b_ext + E_BIAS;
    end

    // ---------------------------------------------------------------- normalise / round
    always_comb begin
        if (qr[NB_ITER-1]) begin
            mant_sum = {1'b0, qr[NB_ITER-1:2]} + {{NB_MANT{1'b0}}, qr[1]};
            exp_norm = exp_q;
        end else begin
            mant_sum = {1'b0, qr[NB_ITER-2:1]} + {{NB_MANT{1'b0}}, qr[0]};
            exp_norm = exp_q - E_ONE;
        end
        // Carry-out only possible for non-normalised operands; saturate instead of wrapping.
        mant_rnd = mant_sum[NB_MANT] ? {NB_MANT{1'b1}} : mant_sum[NB_MANT-1:0];

        if (spec_hit_q) begin
            quot_d = spec_val_q;
        end else if (exp_norm > E_MAX) begin
            quot_d = {sign_q, MAG_INF};
        end else if (exp_norm[NB_E-1]) begin
            quot_d = {sign_q, MAG_ZERO};
        end else begin
            quot_d = {sign_q, exp_norm[NB_EXP-1:0], mant_rnd};
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            spec_hit_q <= 1'b0;
            spec_val_q <= '0;
            quot_q     <= {1'b0, MAG_ZERO};
        end else begin
            if (start) begin
                sign_q     <= sign_in;
                exp_q      <= exp_in;
                spec_hit_q <= spec_hit_d;
                spec_val_q <= spec_val_d;
            end
            if (norm_en) begin
                quot_q <= quot_d;
            end
        end
    end

    assign o_quot = quot_q;

    fpdiv_mant_core #(
        .NB_MANT (NB_MANT),
        .NB_ITER (NB_ITER)
    ) u_mant_core (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .start_i (start),
        .m1_i    (i_dividend[NB_MANT-1:0]),
        .m2_i    (i_divisor[NB_MANT-1:0]),
        .qr_o    (qr),
        .done_o  (core_done)
    );

endmodule
